// File: rtl/encoder_8to3_pending_pkg.sv
// ---------------------------------------------------------------------------
// encoder_pkg
// Shared constants, FSM state type and the onehot-to-index helper for the
// registered 8-to-3 pending-event encoder.
//   N_LINES       : number of event lines (8)
//   CODE_W        : width of the binary code (3)
//   state_e       : presentation FSM states {IDLE, PRESENT}
//   onehot_to_idx : converts a one-hot grant vector to its binary index
// ---------------------------------------------------------------------------
package encoder_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // OR-reduction of set bit positions; exact for a one-hot input, 0 for all-zero.
  function automatic logic [CODE_W-1:0] onehot_to_idx(input logic [N_LINES-1:0] oh);
    logic [CODE_W-1:0] idx;
    idx = {CODE_W{1'b0}};
    for (int i = 0; i < N_LINES; i++) begin
      if (oh[i]) begin
        idx = idx | CODE_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/encoder_8to3_pending_if.sv
// ---------------------------------------------------------------------------
// encoder_8to3_pending_if
// Event/handshake bundle between the event sources + consumer and the encoder.
//   d       : event lines, d[i] maps to code i
//   ack     : consumer accepts the presented code (meaningful while valid)
//   valid   : code holds a pending index
//   code    : binary index, code[2] is the MSB
//   pending : current pending register
//   lost    : sticky overflow flag
// Modports: slave = encoder side, master = source/consumer side.
// ---------------------------------------------------------------------------
interface encoder_8to3_pending_if
  import encoder_pkg::*;
  ();

  logic [N_LINES-1:0] d;
  logic               ack;
  logic               valid;
  logic [CODE_W-1:0]  code;
  logic [N_LINES-1:0] pending;
  logic               lost;

  modport slave (
    input  d,
    input  ack,
    output valid,
    output code,
    output pending,
    output lost
  );

  modport master (
    output d,
    output ack,
    input  valid,
    input  code,
    input  pending,
    input  lost
  );

endinterface

// File: rtl/encoder_8to3_pending_prio_pick8.sv
// ---------------------------------------------------------------------------
// prio_pick8
// Combinational priority picker over 8 request lines. The search starts at
// index `top` and walks downward, wrapping 0 -> 7; the first request found
// wins. With top tied to 7 this is a plain highest-index-wins encoder.
//   req : request vector
//   top : highest-priority index
//   any : at least one request is set
//   idx : index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module prio_pick8
  import encoder_pkg::*;
  (
  input  logic [N_LINES-1:0] req,
  input  logic [CODE_W-1:0]  top,
  output logic               any,
  output logic [CODE_W-1:0]  idx
);

  logic [N_LINES-1:0] grant_s;
  logic [CODE_W-1:0]  probe_s;
  logic               found_s;

  // Downward circular search from top, producing a one-hot grant.
  always_comb begin
    grant_s = {N_LINES{1'b0}};
    found_s = 1'b0;
    probe_s = top;
    for (int k = 0; k < N_LINES; k++) begin
      probe_s = top - CODE_W'(k);
      if (!found_s && req[probe_s]) begin
        grant_s[probe_s] = 1'b1;
        found_s          = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;
  assign idx = onehot_to_idx(grant_s);

endmodule

// File: rtl/encoder_8to3_pending.sv
// ---------------------------------------------------------------------------
// encoder_8to3_pending
// Registered 8-to-3 encoder with a pending-event register and valid/ack
// handshake. Events on d are captured into `pending`, then presented one at a
// time in priority order (highest index first). Acked codes are cleared; a
// new event in the same cycle as its clear re-queues the line.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : encoder_8to3_pending_if.slave (d, ack in; valid, code, pending,
//           lost out)
// Parameter:
//   LEVEL_MODE : 0 = capture rising edges of d, 1 = high level sets pending
// Build option:
//   ROTATE_PRIORITY_EN : rotating priority; after acking index i the search
//                        starts at i-1 so the serviced line becomes lowest.
// ---------------------------------------------------------------------------
module encoder_8to3_pending
  import encoder_pkg::*;
  #(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  encoder_8to3_pending_if.slave  bus
);

  state_e             state_q, state_d;
  logic [N_LINES-1:0] d_q, d_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               valid_q, valid_d;
  logic               lost_q, lost_d;

  logic [N_LINES-1:0] set_s;
  logic [N_LINES-1:0] clr_s;
  logic [N_LINES-1:0] rem_s;
  logic               ack_s;
  logic [CODE_W-1:0]  top_s;
  logic               pick_any_s;
  logic [CODE_W-1:0]  pick_idx_s;

  // Event capture, pending update and sticky overflow detection.
  always_comb begin
    d_d = bus.d;
    if (LEVEL_MODE == 1'b1) begin
      set_s = bus.d;
    end else begin
      set_s = bus.d & ~d_q;
    end
    if (valid_q && bus.ack) begin
      ack_s = 1'b1;
      clr_s = {{(N_LINES-1){1'b0}}, 1'b1} << code_q;
    end else begin
      ack_s = 1'b0;
      clr_s = {N_LINES{1'b0}};
    end
    // rem excludes the acked line; events set this cycle are not in it.
    rem_s     = pending_q & ~clr_s;
    pending_d = rem_s | set_s;
    lost_d    = lost_q | (|(set_s & rem_s));
  end

`ifdef ROTATE_PRIORITY_EN
  logic [CODE_W-1:0] top_q, top_d;

  // Serviced line drops to lowest priority.
  always_comb begin
    if (ack_s) begin
      top_d = code_q - 3'd1;
    end else begin
      top_d = top_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_q <= 3'd7;
    end else begin
      top_q <= top_d;
    end
  end

  // The pick for this cycle already uses the post-ack pointer.
  assign top_s = top_d;
`else
  assign top_s = 3'd7;
`endif

  // In IDLE clr is zero, so rem equals pending and one picker serves both cases.
  prio_pick8 u_pick (
    .req (rem_s),
    .top (top_s),
    .any (pick_any_s),
    .idx (pick_idx_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (ack_s && !pick_any_s) begin
          state_d = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: code only reloads on entry to PRESENT or on an ack.
  always_comb begin
    valid_d = (state_d == PRESENT);
    if (((state_q == IDLE) || ack_s) && pick_any_s) begin
      code_d = pick_idx_s;
    end else begin
      code_d = code_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q       <= 8'h00;
      pending_q <= 8'h00;
      code_q    <= 3'b000;
      valid_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      d_q       <= d_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      lost_q    <= lost_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.code    = code_q;
  assign bus.pending = pending_q;
  assign bus.lost    = lost_q;

endmodule
